ps2_scancode_decoder: RTL

Consumes the raw byte stream produced by `PS2_Controller` (`received_data` / `received_data_en`) and turns PS/2 Set-2 scan-code sequences into single key events (code, extended flag, make/break flag). Handles `E0`/`F0` prefixes and the 8-byte Pause sequence, and drops keyboard status bytes. Events are buffered in a 4-entry FIFO behind a valid/ready handshake for the benchmark game logic.

---
 rtl/ps2_scancode_decoder.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the raw PS/2 Set-2 byte stream from PS2_Controller into key events.
// It handles the E0 and F0 prefixes and the 8-byte Pause sequence, and it drops
// keyboard status bytes. Events are queued in a show-ahead FIFO that the
// consumer reads through a valid/ready handshake.
//
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat
// makes of the key that is currently held down.
//
// Ports:
//   CLOCK_50          in   system clock, rising edge
//   resetn            in   asynchronous active-low reset
//   received_data     in   [7:0] byte from PS2_Controller
//   received_data_en  in   one-cycle strobe qualifying received_data
//   ev_code           out  [7:0] head event scan code (holds its value when empty)
//   ev_ext            out  head event had an E0 prefix (also set for Pause)
//   ev_rel            out  head event is a break
//   ev_valid          out  FIFO not empty
//   ev_ready          in   consumer accepts the head when ev_valid & ev_ready
//   overflow          out  one-cycle pulse: event dropped because the FIFO was full
//   proto_err         out  one-cycle pulse: illegal prefix order
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow,
  output logic       proto_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] pause_cnt_q, pause_cnt_d;
  logic       emit;
  ev_t        emit_ev;
  logic       proto_err_d;
  logic       is_prefix;
  logic       is_status;
  logic       push_req;

  ev_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ev_t              head_q, head_d;
  logic             valid_q;
  logic             overflow_q, proto_err_q;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             overflow_d;

  assign is_prefix = (received_data == 8'hE0) || (received_data == 8'hF0) ||
                     (received_data == 8'hE1);
  assign is_status = (received_data == 8'hAA) || (received_data == 8'hFA) ||
                     (received_data == 8'hFE) || (received_data == 8'hEE) ||
                     (received_data == 8'h00) || (received_data == 8'hFF);

  // Decoder state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pause_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  // Decoder next-state and event generation; advances only on strobes
  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    emit        = 1'b0;
    emit_ev     = '0;
    proto_err_d = 1'b0;
    if (received_data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (received_data == 8'hE0) begin
            state_d = ST_E0;
          end else if (received_data == 8'hF0) begin
            state_d = ST_F0;
          end else if (received_data == 8'hE1) begin
            state_d     = ST_PAUSE;
            pause_cnt_d = 3'd7;
          end else if (!is_status) begin
            emit    = 1'b1;
            emit_ev = '{ext: 1'b0, rel: 1'b0, code: received_data};
          end
        end
        ST_E0: begin
          state_d = ST_IDLE;
          if (received_data == 8'hF0) begin
            state_d = ST_E0F0;
          end else if (is_prefix) begin
            proto_err_d = 1'b1;
          end else if (received_data != 8'h12) begin
            emit    = 1'b1;
            emit_ev = '{ext: 1'b1, rel: 1'b0, code: received_data};
          end
        end
        ST_F0: begin
          state_d = ST_IDLE;
          if (is_prefix) begin
            proto_err_d = 1'b1;
          end else begin
            emit    = 1'b1;
            emit_ev = '{ext: 1'b0, rel: 1'b1, code: received_data};
          end
        end
        ST_E0F0: begin
          state_d = ST_IDLE;
          if (is_prefix) begin
            proto_err_d = 1'b1;
          end else if (received_data != 8'h12) begin
            emit    = 1'b1;
            emit_ev = '{ext: 1'b1, rel: 1'b1, code: received_data};
          end
        end
        ST_PAUSE: begin
          // Pause bytes are consumed blindly; the last one yields a single event
          if (pause_cnt_q == 3'd1) begin
            state_d     = ST_IDLE;
            pause_cnt_d = 3'd0;
            emit        = 1'b1;
            emit_ev     = '{ext: 1'b1, rel: 1'b0, code: 8'hE1};
          end else begin
            pause_cnt_d = pause_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          pause_cnt_d = 3'd0;
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid_q;
  logic       held_ext_q;
  logic [7:0] held_code_q;
  logic       held_match;

  assign held_match = held_valid_q && (held_ext_q == emit_ev.ext) &&
                      (held_code_q == emit_ev.code);
  // Repeated makes of the held key are auto-repeats and are not queued
  assign push_req   = emit && !(!emit_ev.rel && held_match);

  // Held-key tracking
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
    end else if (emit) begin
      if (!emit_ev.rel) begin
        held_valid_q <= 1'b1;
        held_ext_q   <= emit_ev.ext;
        held_code_q  <= emit_ev.code;
      end else if (held_match) begin
        held_valid_q <= 1'b0;
      end
    end
  end
`else
  assign push_req = emit;
`endif

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = valid_q && ev_ready;
  assign push_ok    = push_req && (!full || pop);
  assign overflow_d = push_req && full && !pop;

  // FIFO pointer, occupancy and show-ahead head computation
  always_comb begin
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head_d = head_q;
    if (count_d != '0) begin
      // The new head may be the entry being written on this same edge
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = emit_ev;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  // FIFO storage (no reset needed; occupancy qualifies every read)
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= emit_ev;
    end
  end

  // FIFO control and registered outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= (count_d != '0);
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ev_code   = head_q.code;
  assign ev_ext    = head_q.ext;
  assign ev_rel    = head_q.rel;
  assign ev_valid  = valid_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule
